// File: rtl/framebuffer_mem_slave_pkg.sv
// Bus control-field positions and slave FSM encoding shared with bus masters.
// No logic; constants and types only.
package framebuffer_mem_slave_pkg;

    localparam int WAIT_BIT  = 0;
    localparam int BURST_LSB = 1;
    localparam int BURST_MSB = 3;
    localparam int WE_BIT    = 4;

    localparam int PIX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_e;

endpackage

// File: rtl/framebuffer_mem_slave_sync_ram.sv
// Single-clock RAM, one write and one registered read port; read data valid one cycle after address.
// No backpressure; read and write ports are independent.
module sync_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/framebuffer_mem_slave.sv
// Framebuffer bus slave: decode grant, hold wait for LATENCY cycles, then one 16-bit beat per cycle.
// First read beat at grant+1+LATENCY; master backpressure is bus_ack, dropping it aborts the burst.
module framebuffer_mem_slave
    import framebuffer_mem_slave_pkg::*;
#(
    parameter int                   BUS_WIDTH  = 32,
    parameter int                   CTRL_WIDTH = 8,
    parameter int                   DEPTH      = 1024,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR  = 32'h0000_8000,
    parameter int                   LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_ack,
    input  logic [BUS_WIDTH-1:0]  bus_in,
    input  logic [CTRL_WIDTH-1:0] ctrl_in,
    output logic [BUS_WIDTH-1:0]  bus_out,
    output logic [CTRL_WIDTH-1:0] ctrl_out
);

    localparam int                 AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BUS_WIDTH:0] END_ADDR  = {1'b0, BASE_ADDR} + (BUS_WIDTH+1)'(DEPTH);
    localparam logic [AW-1:0]      LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [2:0]         LAT_LAST  = 3'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    len_q, len_d;
    logic [2:0]    beat_q, beat_d;
    logic [2:0]    lat_q, lat_d;
    logic          we_q, we_d;

    logic          in_range;
    logic [AW-1:0] grant_off;
    logic [AW-1:0] addr_nxt;
    logic [AW-1:0] rd_addr;
    logic          beat_vld;
    logic          wr_en;
    logic [PIX_W-1:0] rd_dat;
    logic          unused_ctrl;

    assign unused_ctrl = ^{ctrl_in[WAIT_BIT], ctrl_in[CTRL_WIDTH-1:WE_BIT+1]};

    assign in_range  = ({1'b0, bus_in} >= {1'b0, BASE_ADDR}) && ({1'b0, bus_in} < END_ADDR);
    // Offset is below DEPTH, so the low AW bits of the difference are exact.
    assign grant_off = bus_in[AW-1:0] - BASE_ADDR[AW-1:0];
    assign addr_nxt  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

    // Read one beat ahead: the last WAIT cycle fetches beat 0, each XFER beat fetches the next.
    assign rd_addr = (state_q == XFER) ? addr_nxt : addr_q;
    assign wr_en   = beat_vld && we_q && !reset;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        lat_d    = lat_q;
        we_d     = we_q;
        beat_vld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus_ack && in_range) begin
                    state_d = WAIT;
                    addr_d  = grant_off;
                    len_d   = ctrl_in[BURST_MSB:BURST_LSB];
                    we_d    = ctrl_in[WE_BIT];
                    beat_d  = '0;
                    lat_d   = '0;
                end
            end
            WAIT: begin
                if (!bus_ack) begin
                    state_d = IDLE;
                end else if (lat_q == LAT_LAST) begin
                    state_d = XFER;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            XFER: begin
                if (!bus_ack) begin
                    state_d = IDLE;
                end else begin
                    beat_vld = 1'b1;
                    addr_d   = addr_nxt;
                    beat_d   = beat_q + 1'b1;
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_out  = '0;
        ctrl_out = '0;
        if (!reset) begin
            ctrl_out[WAIT_BIT] = (state_q == WAIT);
            if (beat_vld && !we_q) begin
                bus_out = {{(BUS_WIDTH-PIX_W){1'b0}}, rd_dat};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            we_q    <= we_d;
        end
    end

    sync_ram #(
        .WIDTH (PIX_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (addr_q),
        .wdata_i (bus_in[PIX_W-1:0]),
        .raddr_i (rd_addr),
        .rdata_o (rd_dat)
    );

endmodule

// File: doc/framebuffer_mem_slave.md
FRAMEBUFFER_MEM_SLAVE -- requirements
Module: framebuffer_mem_slave

Interface
REQ-001 SHALL have parameter BUS_WIDTH, 32, bus data/address width.
REQ-002 SHALL have parameter CTRL_WIDTH, 8, control bus width.
REQ-003 SHALL have parameter DEPTH, 1024, number of 16-bit words stored.
REQ-004 SHALL have parameter BASE_ADDR, 32'h0000_8000, first word address decoded.
REQ-005 SHALL have parameter LATENCY, 2, wait cycles before the first data beat (1..7).
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port bus_ack  input  1  grant; high for the whole transaction.
REQ-009 SHALL have port bus_in  input  BUS_WIDTH  address in the grant cycle, write data in write beats.
REQ-010 SHALL have port ctrl_in  input  CTRL_WIDTH  [3:1] burst length minus 1; [4] write=1/read=0; other bits ignored.
REQ-011 SHALL have port bus_out  output  BUS_WIDTH  read data, zero-extended from 16 bits; 0 when not driving a beat.
REQ-012 SHALL have port ctrl_out  output  CTRL_WIDTH  [0] wait; all other bits 0.

Function
REQ-013 SHALL implement states IDLE, WAIT, XFER.
REQ-014 IDLE: bus_ack=1 with BASE_ADDR <= bus_in < BASE_ADDR+DEPTH SHALL latch offset, burst length and direction, then go to WAIT next cycle.
REQ-015 IDLE: an out-of-range address SHALL be ignored (stay IDLE, wait=0, bus_out=0).
REQ-016 WAIT SHALL hold ctrl_out[0]=1 for exactly LATENCY cycles, then go to XFER.
REQ-017 XFER SHALL drive ctrl_out[0]=0 and complete one beat per cycle for burst length N = ctrl_in[3:1]+1 (1..8).
REQ-018 A read beat k SHALL present mem[(offset+k) mod DEPTH] on bus_out[15:0] in that cycle, with bus_out[31:16]=0.
REQ-019 A write beat k SHALL write bus_in[15:0] to mem[(offset+k) mod DEPTH] at the end of that cycle; bus_out stays 0.
REQ-020 The beat address SHALL wrap from DEPTH-1 to 0 within a burst.
REQ-021 After beat N-1, the FSM SHALL return to IDLE; a new grant is accepted no earlier than the following cycle.
REQ-022 bus_ack=0 in WAIT or XFER SHALL abort: return to IDLE next cycle, with no write in that cycle and no further beats.
REQ-023 Read data latency from grant cycle T SHALL be first beat at T+1+LATENCY.
REQ-024 Storage SHALL be synchronous-read memory; the read for beat k is issued one cycle ahead so REQ-018 holds.

Reset
REQ-025 reset=1 SHALL force IDLE, ctrl_out=0, bus_out=0 and clear latched offset, count and direction on the same edge.
REQ-026 Reset SHALL take priority over any grant or beat in the same cycle; memory contents are not cleared.
REQ-027 Reset mid-burst SHALL abort with no write on the reset cycle.

Structure
REQ-028 The bus ctrl field positions (WAIT_BIT=0, BURST_LSB=1, BURST_MSB=3, WE_BIT=4) and the state encoding SHALL live in the shared bus package also used by bus masters.
REQ-029 The memory array SHALL be one sub-module, sync_ram (width 16, depth DEPTH, one read and one write port); the FSM, counters and decode stay in the top level.

Verification
REQ-030 Single read: mem[5]=16'hA5C3, grant with address BASE+5, ctrl=0 -> wait=1 for 2 cycles, then bus_out=32'h0000A5C3 for 1 cycle, then IDLE.
REQ-031 Write burst: address BASE+10, ctrl[3:1]=3, ctrl[4]=1, data 1,2,3,4 -> mem[10..13]=1..4; then a read burst of 4 returns 1,2,3,4 on consecutive cycles.
REQ-032 Wrap: read burst of 4 at BASE+DEPTH-2 -> data from mem[DEPTH-2], mem[DEPTH-1], mem[0], mem[1].
REQ-033 Decode: grant with address BASE-1 or BASE+DEPTH -> wait stays 0, bus_out stays 0, and no memory change.
REQ-034 Abort: drop bus_ack after beat 1 of an 8-beat write -> only beats 0 and 1 written; IDLE next cycle.
REQ-035 Reset: assert reset during WAIT -> next cycle wait=0 and bus_out=0; a following grant is serviced normally.
